// File: rtl/median_window_feeder.sv
// median_window_feeder
//   Source side of the 3-tap vertical median datapath. Converts a raster pixel
//   stream into vertically aligned column triples (two rows above, one row
//   above, current) using two circular line buffers indexed by column.
//
//   State  | meaning
//   -------+-----------------------------------------------------------------
//   FILL0  | priming row 0 of the frame, no output
//   FILL1  | priming row 1 of the frame, no output
//   RUN    | rows 2..FRAME_ROWS-1, one triple per accepted pixel
//   DRAIN  | last pixel of frame accepted, waiting for its triple to be taken
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   pix_valid/pix_ready   input handshake, pix_data raster pixel
//   out_valid/out_ready   output handshake, word0 (oldest row) .. word2 (current)
//   frame_done            1-cycle pulse after the last triple of a frame is taken
module median_window_feeder #(
  parameter int WIDTH      = 32,
  parameter int LINE_LEN   = 64,
  parameter int FRAME_ROWS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [WIDTH-1:0] pix_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] word0,
  output logic [WIDTH-1:0] word1,
  output logic [WIDTH-1:0] word2,
  output logic             frame_done
);

  localparam int CW = $clog2(LINE_LEN);
  localparam int RW = $clog2(FRAME_ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_ROWS - 1);

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [WIDTH-1:0] buf_a [LINE_LEN];
  logic [WIDTH-1:0] buf_b [LINE_LEN];

  logic acc;
  logic take;
  logic col_wrap;
  logic last_pix;

  // In RUN the single output register may be refilled in the same cycle it is
  // taken, so back-to-back triples flow without a bubble.
  always_comb begin
    pix_ready = 1'b0;
    case (state)
      FILL0, FILL1: pix_ready = 1'b1;
      RUN:          pix_ready = !out_valid || out_ready;
      default:      pix_ready = 1'b0;
    endcase
  end

  assign acc      = pix_valid && pix_ready;
  assign take     = out_valid && out_ready;
  assign col_wrap = (col == COL_LAST);
  assign last_pix = col_wrap && (row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL0: if (acc && col_wrap) state_nxt = FILL1;
      FILL1: if (acc && col_wrap) state_nxt = RUN;
      RUN:   if (acc && last_pix) state_nxt = DRAIN;
      DRAIN: if (take)            state_nxt = FILL0;
      default:                    state_nxt = FILL0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      word0      <= '0;
      word1      <= '0;
      word2      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && take;
      if (acc) begin
        if (col_wrap) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if ((state == RUN) && acc) begin
        word0     <= buf_a[col];
        word1     <= buf_b[col];
        word2     <= pix_data;
        out_valid <= 1'b1;
      end else if (take) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Line buffers are plain storage: priming overwrites them before use, so
  // they need no reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      buf_a[col] <= buf_b[col];
      buf_b[col] <= pix_data;
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
module tb_median_window_feeder;

  localparam int WIDTH      = 32;
  localparam int LINE_LEN   = 4;
  localparam int FRAME_ROWS = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             pix_valid = 1'b0;
  logic             pix_ready;
  logic [WIDTH-1:0] pix_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] word0, word1, word2;
  logic             frame_done;

  median_window_feeder #(
    .WIDTH(WIDTH), .LINE_LEN(LINE_LEN), .FRAME_ROWS(FRAME_ROWS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .word0(word0), .word1(word1), .word2(word2),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] w0;
    logic [WIDTH-1:0] w1;
    logic [WIDTH-1:0] w2;
    logic             last;
  } trip_t;

  trip_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int drv_row = 0, drv_col = 0, drv_frame = 0;
  bit drain_pending = 0;
  bit exp_fd = 0;
  int fd_seen = 0;
  int takes = 0;
  int accepts = 0;

  function automatic logic [WIDTH-1:0] pval(input int f, input int r, input int c);
    return WIDTH'(f * 256 + r * 16 + c);
  endfunction

  // One clock: drive, check at negedge against the model, update the model
  // with the handshakes that complete on the coming rising edge.
  task automatic cycle(input bit pv, input bit ordy);
    bit exp_rdy, acc, take;
    trip_t t;
    pix_valid = pv;
    out_ready = ordy;
    pix_data  = pv ? pval(drv_frame, drv_row, drv_col) : WIDTH'($urandom);
    @(negedge clk);
    exp_rdy = drain_pending ? 1'b0 : (drv_row < 2) ? 1'b1 : (exp_q.size() == 0 || ordy);
    n_cmp++;
    if (pix_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL pix_ready: got %b want %b (row %0d col %0d)", pix_ready, exp_rdy, drv_row, drv_col);
    end
    n_cmp++;
    if (out_valid !== (exp_q.size() != 0)) begin
      n_err++;
      $display("FAIL out_valid: got %b want %b", out_valid, exp_q.size() != 0);
    end
    n_cmp++;
    if (frame_done !== exp_fd) begin
      n_err++;
      $display("FAIL frame_done: got %b want %b", frame_done, exp_fd);
    end
    if (frame_done === 1'b1) fd_seen++;
    exp_fd = 1'b0;
    if (exp_q.size() != 0) begin
      n_cmp++;
      if ({word0, word1, word2} !== {exp_q[0].w0, exp_q[0].w1, exp_q[0].w2}) begin
        n_err++;
        $display("FAIL words: got %h/%h/%h want %h/%h/%h", word0, word1, word2,
                 exp_q[0].w0, exp_q[0].w1, exp_q[0].w2);
      end
    end
    acc  = pv && (pix_ready === 1'b1);
    take = ordy && (out_valid === 1'b1);
    if (take) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_triple: got %h/%h/%h want none", word0, word1, word2);
      end else begin
        t = exp_q.pop_front();
        takes++;
        if (t.last) begin
          exp_fd = 1'b1;
          drain_pending = 1'b0;
        end
      end
    end
    if (acc) begin
      accepts++;
      if (drv_row >= 2) begin
        t.w0 = pval(drv_frame, drv_row - 2, drv_col);
        t.w1 = pval(drv_frame, drv_row - 1, drv_col);
        t.w2 = pval(drv_frame, drv_row, drv_col);
        t.last = (drv_row == FRAME_ROWS - 1) && (drv_col == LINE_LEN - 1);
        exp_q.push_back(t);
        if (t.last) drain_pending = 1'b1;
      end
      if (drv_col == LINE_LEN - 1) begin
        drv_col = 0;
        if (drv_row == FRAME_ROWS - 1) begin
          drv_row = 0;
          drv_frame++;
        end else begin
          drv_row++;
        end
      end else begin
        drv_col++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input bit ordy);
    int start, cyc;
    start = accepts;
    cyc = 0;
    while (accepts - start < n && cyc < 4 * n + 20) begin
      cycle(1'b1, ordy);
      cyc++;
    end
    n_cmp++;
    if (accepts - start != n) begin
      n_err++;
      $display("FAIL stream_timeout: got %0d accepts want %0d", accepts - start, n);
    end
  endtask

  task automatic finish_frame();
    int cyc;
    cyc = 0;
    while (drain_pending && cyc < 20) begin
      cycle(1'b0, 1'b1);
      cyc++;
    end
    n_cmp++;
    if (drain_pending) begin
      n_err++;
      $display("FAIL drain_timeout: got pending after %0d cycles want drained", cyc);
    end
    cycle(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if ({word0, word1, word2} !== '0) begin
      n_err++;
      $display("FAIL reset_words: got %h/%h/%h want 0", word0, word1, word2);
    end
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_frame_done: got %b want 0", frame_done);
    end
    exp_q.delete();
    drv_row = 0;
    drv_col = 0;
    drv_frame = 0;
    drain_pending = 0;
    exp_fd = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (pix_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pix_ready: got %b want 1", pix_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_priming();
    stream(2 * LINE_LEN, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL priming_out_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_first_triple();
    stream(2, 1'b1);
    n_cmp++;
    if ({out_valid, word0, word1, word2} !== {1'b1, 32'h01, 32'h11, 32'h21}) begin
      n_err++;
      $display("FAIL first_triple: got %b %h/%h/%h want 1 01/11/21", out_valid, word0, word1, word2);
    end
    stream(6, 1'b1);
    finish_frame();
  endtask

  task automatic test_back_to_back();
    int t0, f0, c0;
    do_reset();
    t0 = takes;
    f0 = fd_seen;
    c0 = accepts;
    for (int i = 0; i < LINE_LEN * FRAME_ROWS; i++) cycle(1'b1, 1'b1);
    n_cmp++;
    if (accepts - c0 != LINE_LEN * FRAME_ROWS) begin
      n_err++;
      $display("FAIL b2b_accepts: got %0d want %0d", accepts - c0, LINE_LEN * FRAME_ROWS);
    end
    n_cmp++;
    if ({word0, word1, word2} !== {32'h13, 32'h23, 32'h33}) begin
      n_err++;
      $display("FAIL b2b_last_words: got %h/%h/%h want 13/23/33", word0, word1, word2);
    end
    finish_frame();
    n_cmp++;
    if (takes - t0 != 8) begin
      n_err++;
      $display("FAIL b2b_triples: got %0d want 8", takes - t0);
    end
    n_cmp++;
    if (fd_seen - f0 != 1) begin
      n_err++;
      $display("FAIL b2b_frame_done: got %0d pulses want 1", fd_seen - f0);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held;
    int t0;
    t0 = takes;
    stream(3 * LINE_LEN + 2, 1'b1);
    held = pval(drv_frame, 3, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0);
      n_cmp++;
      if ({pix_ready, out_valid, word2} !== {1'b0, 1'b1, held}) begin
        n_err++;
        $display("FAIL stall_hold: got rdy %b vld %b w2 %h want 0 1 %h", pix_ready, out_valid, word2, held);
      end
    end
    stream(2, 1'b1);
    finish_frame();
    n_cmp++;
    if (takes - t0 != 8) begin
      n_err++;
      $display("FAIL stall_triples: got %0d want 8", takes - t0);
    end
  endtask

  task automatic test_reset_mid();
    stream(2 * LINE_LEN + 3, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_before_reset: got %b want 1", out_valid);
    end
    do_reset();
    stream(2 * LINE_LEN, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_primed_early: got %b want 0", out_valid);
    end
    stream(1, 1'b1);
    n_cmp++;
    if ({out_valid, word2} !== {1'b1, pval(0, 2, 0)}) begin
      n_err++;
      $display("FAIL mid_first_triple: got %b %h want 1 %h", out_valid, word2, pval(0, 2, 0));
    end
    stream(7, 1'b1);
    finish_frame();
  endtask

  task automatic test_random();
    int f0, cyc;
    f0 = fd_seen;
    cyc = 0;
    while (fd_seen - f0 < 3 && cyc < 3000) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      cyc++;
    end
    n_cmp++;
    if (fd_seen - f0 != 3) begin
      n_err++;
      $display("FAIL random_frames: got %0d frames want 3", fd_seen - f0);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_leftover: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_priming();
    test_first_triple();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
